// File: rtl/io_pkg.sv
// Shared address map and status bit positions for the memory-mapped I/O port block.
package io_pkg;

  localparam logic [31:0] IO_BASE     = 32'h0000_0080;
  localparam logic [31:0] ADDR_IN0    = 32'h0000_0080;
  localparam logic [31:0] ADDR_IN1    = 32'h0000_0084;
  localparam logic [31:0] ADDR_OUT2   = 32'h0000_0088;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_008C;

  localparam int STATUS_CHG0 = 0;
  localparam int STATUS_CHG1 = 1;

  // Word match: byte offset bits [1:0] never take part in the decode.
  function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter for one switch group; the accepted
// value and its one-cycle accept pulse are registered once more before leaving.
module switch_debouncer #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             accept_pulse
);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] held_q, held_d;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;

  always_comb begin
    held_d   = held_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    if (sync_q == held_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // Whatever sync holds right now is accepted, even if it moved mid-count.
      held_d   = sync_q;
      cnt_d    = '0;
      accept_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q   <= '0;
      sync_q   <= '0;
      held_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      out_q    <= held_q;
      accept_q <= accept_d;
    end
  end

  assign stable       = out_q;
  assign accept_pulse = accept_q;

endmodule

// File: rtl/io_port_controller.sv
// Memory-mapped I/O block: debounced switch input ports, three CPU-written output
// ports and a sticky read-to-clear / write-1-to-clear change status register.
module io_port_controller
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  switch,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        io_sel,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        irq
);

  logic [4:0]  sw0_stable, sw1_stable;
  logic        acc0, acc1;
  logic        hit_in0, hit_in1, hit_out2, hit_status;
  logic [31:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
  logic [1:0]  status_q, status_d;
  logic        unused_addr_bits;

  switch_debouncer #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb0 (
    .clock(clock), .resetn(resetn), .raw(switch[9:5]), .stable(sw0_stable), .accept_pulse(acc0)
  );

  switch_debouncer #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb1 (
    .clock(clock), .resetn(resetn), .raw(switch[4:0]), .stable(sw1_stable), .accept_pulse(acc1)
  );

  assign unused_addr_bits = ^addr[1:0];
  assign io_sel     = (addr[31:8] == 24'd0) && addr[7];
  assign hit_in0    = reg_hit(addr, ADDR_IN0);
  assign hit_in1    = reg_hit(addr, ADDR_IN1);
  assign hit_out2   = reg_hit(addr, ADDR_OUT2);
  assign hit_status = reg_hit(addr, ADDR_STATUS);

  always_comb begin
    out0_d   = out0_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    status_d = status_q;
    if (we && hit_in0)  out0_d = wdata;
    if (we && hit_in1)  out1_d = wdata;
    if (we && hit_out2) out2_d = wdata;
    if (re && hit_status) status_d = 2'b00;
    if (we && hit_status) status_d = status_d & ~wdata[1:0];
    // New changes are applied last so a same-edge clear never hides them.
    if (acc0) status_d[STATUS_CHG0] = 1'b1;
    if (acc1) status_d[STATUS_CHG1] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out0_q   <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
      status_q <= '0;
    end else begin
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_in0)         rdata = in_port0;
    else if (hit_in1)    rdata = in_port1;
    else if (hit_out2)   rdata = out2_q;
    else if (hit_status) rdata = {30'd0, status_q};
  end

  assign in_port0  = {27'd0, sw0_stable};
  assign in_port1  = {27'd0, sw1_stable};
  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign out_port2 = out2_q;
  assign irq       = |status_q;

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: register-access vector table plus
// hand-written debounce, status-clear and reset sequences.
module tb_io_port_controller;

  logic        clock;
  logic        resetn;
  logic [9:0]  switch;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic        io_sel;
  logic [31:0] in_port0, in_port1, out_port0, out_port1, out_port2;
  logic        irq;

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
    logic [31:0] exp_o0;
    logic [31:0] exp_o1;
    logic [31:0] exp_o2;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  io_port_controller #(.DEBOUNCE_CYCLES(16), .CNT_W(8)) dut (
    .clock(clock), .resetn(resetn), .switch(switch), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .io_sel(io_sel), .in_port0(in_port0),
    .in_port1(in_port1), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    addr = 32'h8C;
    we   = 1'b0;
    re   = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic clear_status();
    addr = 32'h8C;
    re   = 1'b1;
    tick();
    re   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    switch   = 10'h3FF;
    addr     = 32'h0;
    wdata    = 32'h0;
    we       = 1'b0;
    re       = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 32'h80,       32'h2A,        32'h1F, 1'b1, 32'h2A, 32'h0,         32'h0,  1'b1};
    vecs[1]  = '{1'b1, 1'b0, 32'h88,       32'd99,        32'h0,  1'b1, 32'h2A, 32'h0,         32'd99, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h88,       32'h0,         32'd99, 1'b1, 32'h2A, 32'h0,         32'd99, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h40,       32'hDEAD,      32'h0,  1'b0, 32'h2A, 32'h0,         32'd99, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h84,       32'h1234_5678, 32'h1F, 1'b1, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h8C,       32'h1,         32'h3,  1'b1, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h8C,       32'h0,         32'h2,  1'b1, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h90,       32'h0,         32'h0,  1'b1, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h94,       32'hFF,        32'h0,  1'b1, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h100,      32'h0,         32'h0,  1'b0, 32'h2A, 32'h1234_5678, 32'd99, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h83,       32'h55,        32'h1F, 1'b1, 32'h55, 32'h1234_5678, 32'd99, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h8C,       32'h0,         32'h2,  1'b1, 32'h55, 32'h1234_5678, 32'd99, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h8C,       32'h0,         32'h0,  1'b1, 32'h55, 32'h1234_5678, 32'd99, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h88,       32'h7,         32'd99, 1'b1, 32'h55, 32'h1234_5678, 32'h7,  1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h88,       32'h0,         32'h7,  1'b1, 32'h55, 32'h1234_5678, 32'h7,  1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h8000_0080, 32'h1,        32'h0,  1'b0, 32'h55, 32'h1234_5678, 32'h7,  1'b0};

    // Reset with all switches high, then both groups accept on the same edge.
    repeat (3) @(posedge clock);
    #1;
    check("rst_in0", in_port0, 32'h0);
    check("rst_in1", in_port1, 32'h0);
    check("rst_out0", out_port0, 32'h0);
    check("rst_out2", out_port2, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check_status("rst_status", 32'h0);
    check("rst_io_sel", {31'd0, io_sel}, 32'h1);
    resetn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      check("rst_lat_in0", in_port0, 32'h0);
      check("rst_lat_in1", in_port1, 32'h0);
    end
    tick();
    check("rst_acc_in0", in_port0, 32'h1F);
    check("rst_acc_in1", in_port1, 32'h1F);
    check("rst_acc_irq", {31'd0, irq}, 32'h1);
    check_status("rst_acc_status", 32'h3);

    // Register access table.
    for (int i = 0; i < 16; i++) begin
      we    = vecs[i].we;
      re    = vecs[i].re;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_io_sel", i), {31'd0, io_sel}, {31'd0, vecs[i].exp_sel});
      tick();
      we = 1'b0;
      re = 1'b0;
      check($sformatf("vec%0d_out0", i), out_port0, vecs[i].exp_o0);
      check($sformatf("vec%0d_out1", i), out_port1, vecs[i].exp_o1);
      check($sformatf("vec%0d_out2", i), out_port2, vecs[i].exp_o2);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // Return switches to 0, then a 10-cycle glitch on group 0 must be ignored.
    switch = 10'h000;
    repeat (20) tick();
    check("zero_in0", in_port0, 32'h0);
    check("zero_in1", in_port1, 32'h0);
    check_status("zero_status", 32'h3);
    clear_status();
    check_status("zero_cleared", 32'h0);
    switch = {5'h15, 5'h00};
    repeat (10) tick();
    switch = 10'h000;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("glitch_in0", in_port0, 32'h0);
    end
    check_status("glitch_status", 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'h0);

    // Group-0 accept on the same edge as a status read-clear: set wins.
    switch = {5'h0C, 5'h00};
    repeat (18) tick();
    check("coll_pre_in0", in_port0, 32'h0);
    addr = 32'h8C;
    re   = 1'b1;
    #1;
    check("coll_pre_rdata", rdata, 32'h0);
    tick();
    re = 1'b0;
    check("coll_in0", in_port0, 32'h0C);
    check("coll_irq", {31'd0, irq}, 32'h1);
    check_status("coll_status", 32'h1);
    clear_status();
    check_status("coll_cleared", 32'h0);

    // Reset in the middle of a group-1 count, then re-debounce from zero.
    we    = 1'b1;
    addr  = 32'h80;
    wdata = 32'h77;
    tick();
    we = 1'b0;
    check("mid_out0_written", out_port0, 32'h77);
    switch = {5'h0C, 5'h0A};
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_in0", in_port0, 32'h0);
    check("mid_rst_out0", out_port0, 32'h0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      check("mid_lat_in1", in_port1, 32'h0);
    end
    tick();
    check("mid_in1", in_port1, 32'h0A);
    check("mid_in0", in_port0, 32'h0C);
    check_status("mid_status", 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
